// File: rtl/fwd_hazard_unit_if.sv
// Decode/execute boundary bundle for the forwarding and load-use hazard unit.
// Protocol: the decode stage presents one instruction per cycle on the issue_*
// and src_* fields. While stall is high, that instruction is not accepted.
// Decode must present the same instruction again on the next cycle.
interface fwd_hazard_unit_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 2,
   parameter int NPORTS = 2
);
   logic [NPORTS*5-1:0]     src_reg;
   logic [NPORTS-1:0]       src_used;
   logic [NPORTS*WIDTH-1:0] src_data;
   logic [DEPTH*WIDTH-1:0]  stage_data;
   logic                    issue_valid;
   logic                    issue_wr;
   logic                    issue_load;
   logic [4:0]              issue_dst;
   logic                    flush;
   logic [NPORTS*WIDTH-1:0] fwd_data;
   logic                    stall;
   logic [15:0]             stall_cnt;

   modport master (
      output src_reg, src_used, src_data, stage_data,
      output issue_valid, issue_wr, issue_load, issue_dst, flush,
      input  fwd_data, stall, stall_cnt
   );

   modport slave (
      input  src_reg, src_used, src_data, stage_data,
      input  issue_valid, issue_wr, issue_load, issue_dst, flush,
      output fwd_data, stall, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection between decode and execute.
// A DEPTH-entry shift register records the destination of every in-flight
// instruction. Entry 0 is the youngest, and it is the one now in EX.
module fwd_hazard_unit #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 2,
   parameter int NPORTS     = 2,
   parameter int LOAD_STAGE = 1,
   parameter int ZERO_EN    = 1
) (
   input  logic            clk,
   input  logic            reset,
   fwd_hazard_unit_if.slave bus
);

   typedef struct packed {
      logic       vld;
      logic [4:0] dst;
      logic       ld;
   } entry_t;

   entry_t [DEPTH-1:0]      entries;
   logic [NPORTS*WIDTH-1:0] fwdData;
   logic [NPORTS-1:0]       portHit;
   logic                    loadHazard;
   logic                    stallNow;
   logic [15:0]             stallCnt;

   // Register 31 is excluded from matching when it is the hardwired zero.
   function automatic logic entryMatch(entry_t e, logic [4:0] r, logic used);
      return e.vld && used && (e.dst == r) && !((ZERO_EN != 0) && (e.dst == 5'd31));
   endfunction

   // For each port, take the youngest matching stage.
   // If the youngest match is a load that is still too young, flag a hazard.
   always_comb begin
      fwdData    = bus.src_data;
      portHit    = '0;
      loadHazard = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!portHit[p] && entryMatch(entries[k], bus.src_reg[p*5 +: 5], bus.src_used[p])) begin
               portHit[p]                 = 1'b1;
               fwdData[p*WIDTH +: WIDTH]  = bus.stage_data[k*WIDTH +: WIDTH];
               if (entries[k].ld && (k < LOAD_STAGE))
                  loadHazard = 1'b1;
            end
         end
      end
   end

   // A flush kills the dependency, so it also cancels the stall.
   assign stallNow      = loadHazard & ~bus.flush;
   assign bus.fwd_data  = fwdData;
   assign bus.stall     = stallNow;
   assign bus.stall_cnt = stallCnt;

   // Advance the scoreboard by one stage.
   // On a stall, a bubble enters stage 0. On a flush, every entry is cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entries <= '0;
      end else if (bus.flush) begin
         entries <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++)
            entries[k] <= entries[k-1];
         if (stallNow)
            entries[0] <= '0;
         else
            entries[0] <= '{vld: bus.issue_valid & bus.issue_wr,
                            dst: bus.issue_dst,
                            ld:  bus.issue_load};
      end
   end

   // Count stalled cycles. The count saturates and is not cleared by a flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stallCnt <= '0;
      else if (stallNow && (stallCnt != 16'hFFFF))
         stallCnt <= stallCnt + 16'd1;
   end

endmodule
